// File: rtl/bp_be_ptw_walk.sv
// bp_be_ptw_walk: Sv39 hardware page-table walker.
// Issues one PTE load per level and ends with a one-cycle fill or page-fault pulse.
module bp_be_ptw_walk #(
    parameter int vaddr_width_p = 39,
    parameter int paddr_width_p = 56
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [paddr_width_p-13:0] base_ppn_i,
    input  logic [1:0]               priv_mode_i,
    input  logic                     sum_i,
    input  logic                     mxr_i,
    input  logic                     flush_i,
    input  logic                     miss_v_i,
    input  logic                     miss_instr_i,
    input  logic                     miss_load_i,
    input  logic                     miss_store_i,
    input  logic [vaddr_width_p-1:0] miss_vaddr_i,
    output logic                     busy_o,
    output logic                     mem_v_o,
    output logic [paddr_width_p-1:0] mem_paddr_o,
    input  logic                     mem_ready_i,
    input  logic                     mem_data_v_i,
    input  logic [63:0]              mem_data_i,
    output logic                     fill_v_o,
    output logic                     fill_itlb_o,
    output logic [vaddr_width_p-1:0] fill_vaddr_o,
    output logic [paddr_width_p-13:0] fill_ptag_o,
    output logic                     fill_gigapage_o,
    output logic                     fill_megapage_o,
    output logic                     fill_u_o,
    output logic                     fill_x_o,
    output logic                     fill_w_o,
    output logic                     fill_r_o,
    output logic                     instr_page_fault_o,
    output logic                     load_page_fault_o,
    output logic                     store_page_fault_o,
    output logic [vaddr_width_p-1:0] fault_vaddr_o
);

    localparam int ptag_width_lp = paddr_width_p - 12;

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT, DONE, DRAIN
    } state_e;

    state_e r_state;
    state_e w_next;

    logic [vaddr_width_p-1:0] r_vaddr;
    logic                     r_instr;
    logic                     r_load;
    logic                     r_store;
    logic [1:0]               r_level;
    logic [ptag_width_lp-1:0] r_ppn;

    logic                     r_fill_v;
    logic                     r_ifault;
    logic                     r_lfault;
    logic                     r_sfault;
    logic [ptag_width_lp-1:0] r_ptag;
    logic                     r_giga;
    logic                     r_mega;
    logic                     r_u;
    logic                     r_x;
    logic                     r_w;
    logic                     r_r;

    logic [8:0]  w_vpn2;
    logic [8:0]  w_vpn1;
    logic [8:0]  w_vpn0;
    logic [8:0]  w_vpn;
    logic        w_v, w_r, w_w, w_x, w_u, w_a, w_d;
    logic [43:0] w_pte_ppn;
    logic [25:0] w_ppn2;
    logic [8:0]  w_ppn1;
    logic [8:0]  w_ppn0;
    logic        w_invalid;
    logic        w_leaf;
    logic        w_misalign;
    logic        w_perm;
    logic        w_ufault;
    logic        w_leaf_fault;
    logic        w_fault;
    logic        w_fill;
    logic        w_descend;
    logic        w_eval;
    logic        w_accept;
    logic [ptag_width_lp-1:0] w_ptag;
    logic        w_unused;

    assign w_vpn2 = r_vaddr[38:30];
    assign w_vpn1 = r_vaddr[29:21];
    assign w_vpn0 = r_vaddr[20:12];

    always_comb begin
        w_vpn = w_vpn0;
        case (r_level)
            2'd2:    w_vpn = w_vpn2;
            2'd1:    w_vpn = w_vpn1;
            default: w_vpn = w_vpn0;
        endcase
    end

    assign w_v       = mem_data_i[0];
    assign w_r       = mem_data_i[1];
    assign w_w       = mem_data_i[2];
    assign w_x       = mem_data_i[3];
    assign w_u       = mem_data_i[4];
    assign w_a       = mem_data_i[6];
    assign w_d       = mem_data_i[7];
    assign w_pte_ppn = mem_data_i[53:10];
    assign w_ppn2    = mem_data_i[53:28];
    assign w_ppn1    = mem_data_i[27:19];
    assign w_ppn0    = mem_data_i[18:10];
    assign w_unused  = ^{mem_data_i[63:54], mem_data_i[9:8], mem_data_i[5]};

    assign w_invalid  = ~w_v | (~w_r & w_w);
    assign w_leaf     = w_r | w_x;
    assign w_misalign = ((r_level == 2'd2) & (|{w_ppn1, w_ppn0}))
                      | ((r_level == 2'd1) & (|w_ppn0));
    assign w_perm     = (r_instr & ~w_x)
                      | (r_load & ~(w_r | (mxr_i & w_x)))
                      | (r_store & ~w_w);
    // Supervisor may touch user pages for data only with SUM set.
    assign w_ufault   = (w_u & (priv_mode_i == 2'd1) & (r_instr | ~sum_i))
                      | (~w_u & (priv_mode_i == 2'd0));
    assign w_leaf_fault = ~w_a | (r_store & ~w_d) | w_misalign
                        | w_perm | w_ufault;

    assign w_descend = ~w_invalid & ~w_leaf & (r_level != 2'd0);
    assign w_fill    = ~w_invalid & w_leaf & ~w_leaf_fault;
    assign w_fault   = ~w_descend & ~w_fill;
    assign w_eval    = (r_state == WAIT) & mem_data_v_i & ~flush_i;
    assign w_accept  = (r_state == IDLE) & miss_v_i & ~flush_i;

    always_comb begin
        w_ptag = w_pte_ppn;
        case (r_level)
            2'd2:    w_ptag = {w_ppn2, w_vpn1, w_vpn0};
            2'd1:    w_ptag = {w_ppn2, w_ppn1, w_vpn0};
            default: w_ptag = w_pte_ppn;
        endcase
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (w_accept) w_next = SEND;
            SEND: begin
                if (flush_i)          w_next = IDLE;
                else if (mem_ready_i) w_next = WAIT;
            end
            WAIT: begin
                if (flush_i)           w_next = mem_data_v_i ? IDLE : DRAIN;
                else if (mem_data_v_i) w_next = w_descend ? SEND : DONE;
            end
            DONE:  w_next = IDLE;
            DRAIN: if (~flush_i & mem_data_v_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_vaddr  <= '0;
            r_instr  <= 1'b0;
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_level  <= 2'd2;
            r_ppn    <= '0;
            r_fill_v <= 1'b0;
            r_ifault <= 1'b0;
            r_lfault <= 1'b0;
            r_sfault <= 1'b0;
            r_ptag   <= '0;
            r_giga   <= 1'b0;
            r_mega   <= 1'b0;
            r_u      <= 1'b0;
            r_x      <= 1'b0;
            r_w      <= 1'b0;
            r_r      <= 1'b0;
        end else begin
            r_fill_v <= 1'b0;
            r_ifault <= 1'b0;
            r_lfault <= 1'b0;
            r_sfault <= 1'b0;
            if (w_accept) begin
                r_vaddr <= miss_vaddr_i;
                r_instr <= miss_instr_i;
                r_load  <= miss_load_i;
                r_store <= miss_store_i;
                r_level <= 2'd2;
                r_ppn   <= base_ppn_i;
            end
            if (w_eval & w_descend) begin
                r_level <= r_level - 2'd1;
                r_ppn   <= w_pte_ppn;
            end
            if (w_eval & ~w_descend) begin
                r_fill_v <= w_fill;
                r_ifault <= w_fault & r_instr;
                r_lfault <= w_fault & r_load;
                r_sfault <= w_fault & r_store;
            end
            if (w_eval & w_fill) begin
                r_ptag <= w_ptag;
                r_giga <= (r_level == 2'd2);
                r_mega <= (r_level == 2'd1);
                r_u    <= w_u;
                r_x    <= w_x;
                r_w    <= w_w;
                r_r    <= w_r;
            end
        end
    end

    assign busy_o      = (r_state != IDLE);
    assign mem_v_o     = (r_state == SEND);
    assign mem_paddr_o = mem_v_o ? {r_ppn, w_vpn, 3'b000} : '0;

    // A flush arriving in DONE cancels the result pulse of that cycle.
    assign fill_v_o           = r_fill_v & ~flush_i;
    assign instr_page_fault_o = r_ifault & ~flush_i;
    assign load_page_fault_o  = r_lfault & ~flush_i;
    assign store_page_fault_o = r_sfault & ~flush_i;

    assign fill_itlb_o     = r_instr;
    assign fill_vaddr_o    = r_vaddr;
    assign fault_vaddr_o   = r_vaddr;
    assign fill_ptag_o     = r_ptag;
    assign fill_gigapage_o = r_giga;
    assign fill_megapage_o = r_mega;
    assign fill_u_o        = r_u;
    assign fill_x_o        = r_x;
    assign fill_w_o        = r_w;
    assign fill_r_o        = r_r;

endmodule

// File: tb/tb_bp_be_ptw_walk.sv
// tb_bp_be_ptw_walk: directed and random walks against a software Sv39 walk model.
// A bench-side memory answers PTE loads with random ready/data latency.
module tb_bp_be_ptw_walk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [43:0] base_ppn;
    logic [1:0]  priv;
    logic        sum, mxr, flush;
    logic        miss_v, miss_instr, miss_load, miss_store;
    logic [38:0] miss_vaddr;
    logic        busy, mem_v;
    logic [55:0] mem_paddr;
    logic        mem_ready, mem_data_v;
    logic [63:0] mem_data;
    logic        fill_v, fill_itlb;
    logic [38:0] fill_vaddr;
    logic [43:0] fill_ptag;
    logic        giga, mega, fu, fx, fw, fr;
    logic        ipf, lpf, spf;
    logic [38:0] fault_vaddr;

    bp_be_ptw_walk dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .base_ppn_i(base_ppn), .priv_mode_i(priv),
        .sum_i(sum), .mxr_i(mxr), .flush_i(flush),
        .miss_v_i(miss_v), .miss_instr_i(miss_instr),
        .miss_load_i(miss_load), .miss_store_i(miss_store),
        .miss_vaddr_i(miss_vaddr), .busy_o(busy),
        .mem_v_o(mem_v), .mem_paddr_o(mem_paddr),
        .mem_ready_i(mem_ready), .mem_data_v_i(mem_data_v),
        .mem_data_i(mem_data),
        .fill_v_o(fill_v), .fill_itlb_o(fill_itlb),
        .fill_vaddr_o(fill_vaddr), .fill_ptag_o(fill_ptag),
        .fill_gigapage_o(giga), .fill_megapage_o(mega),
        .fill_u_o(fu), .fill_x_o(fx), .fill_w_o(fw), .fill_r_o(fr),
        .instr_page_fault_o(ipf), .load_page_fault_o(lpf),
        .store_page_fault_o(spf), .fault_vaddr_o(fault_vaddr)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // walk setup (type: 0 instr, 1 load, 2 store)
    logic [38:0] t_vaddr;
    int          t_type;
    logic [1:0]  t_priv;
    logic        t_sum, t_mxr;
    logic [43:0] t_base;
    logic [63:0] t_pte [3];
    bit          t_zw;

    int          e_nacc;
    logic [55:0] e_addr [3];
    logic        e_fill, e_fault;
    logic [43:0] e_ptag;
    int          e_lvl;

    logic [55:0] o_addr0;
    logic [43:0] o_ptag;
    logic        o_giga, o_mega, o_itlb, o_fill, o_spf, o_ipf;

    function automatic void model();
        longint unsigned ppn;
        longint unsigned va;
        ppn = t_base;
        va = t_vaddr;
        e_fill = 0; e_fault = 0; e_ptag = 0; e_nacc = 0; e_lvl = 0;
        for (int s = 0; s < 3; s++) begin
            int lvl;
            logic [63:0] p;
            longint unsigned vpn, pppn, span;
            bit pf;
            lvl = 2 - s;
            p = t_pte[s];
            vpn = (va >> (12 + 9 * lvl)) % 512;
            pppn = (p >> 10) % (64'd1 << 44);
            span = 64'd1 << (9 * lvl);
            e_addr[s] = 56'(ppn * 4096 + vpn * 8);
            e_nacc = s + 1;
            if (!p[0] || (!p[1] && p[2])) begin
                e_fault = 1;
                return;
            end
            if (!p[1] && !p[3]) begin
                if (lvl == 0) begin
                    e_fault = 1;
                    return;
                end
                ppn = pppn;
                continue;
            end
            pf = !p[6] || (t_type == 2 && !p[7]) || (pppn % span != 0);
            if (t_type == 0 && !p[3]) pf = 1;
            if (t_type == 1 && !(p[1] || (t_mxr && p[3]))) pf = 1;
            if (t_type == 2 && !p[2]) pf = 1;
            if (t_priv == 1 && p[4] && (t_type == 0 || !t_sum)) pf = 1;
            if (t_priv == 0 && !p[4]) pf = 1;
            e_fault = pf;
            e_fill = !pf;
            e_lvl = lvl;
            e_ptag = 44'((pppn / span) * span + (va >> 12) % span);
            return;
        end
    endfunction

    task automatic idle_in();
        miss_v = 0; mem_ready = 0; mem_data_v = 0; flush = 0;
        mem_data = {$urandom, $urandom};
    endtask

    task automatic set_miss();
        miss_vaddr = t_vaddr;
        miss_instr = (t_type == 0);
        miss_load  = (t_type == 1);
        miss_store = (t_type == 2);
        base_ppn = t_base; priv = t_priv; sum = t_sum; mxr = t_mxr;
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, {fill_v, ipf, lpf, spf}, 4'b0);
    endtask

    task automatic run_walk(input string tag);
        int step = 0;
        bit pend = 0;
        int dly = 0;
        bit done = 0;
        logic [63:0] rsp = 0;
        logic [63:0] lf;
        model();
        o_addr0 = '0; o_ptag = '0; o_giga = 0; o_mega = 0;
        o_itlb = 0; o_fill = 0; o_spf = 0; o_ipf = 0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            idle_in();
            set_miss();
            miss_v = (c == 0);
            if (pend) begin
                if (dly == 0) begin
                    mem_data_v = 1; mem_data = rsp; pend = 0;
                end else dly--;
            end
            #1;
            if (c == 0) chk({tag, "_busy0"}, busy, 0);
            if (mem_v) begin
                if (step >= e_nacc) begin
                    n_vec++; n_err++;
                    $error("FAIL %s_extra_req: observed request %0h expected none",
                           tag, mem_paddr);
                    done = 1;
                end else begin
                    chk({tag, "_addr"}, mem_paddr, e_addr[step]);
                    if (step == 0) o_addr0 = mem_paddr;
                    if (t_zw || $urandom_range(0, 2) != 0) begin
                        mem_ready = 1; pend = 1; rsp = t_pte[step];
                        dly = t_zw ? 0 : $urandom_range(0, 3);
                        step++;
                    end
                end
            end
            if (!done && (fill_v || ipf || lpf || spf)) begin
                done = 1;
                o_fill = fill_v; o_spf = spf; o_ipf = ipf;
                chk({tag, "_fill"}, fill_v, e_fill);
                chk({tag, "_ipf"}, ipf, e_fault && t_type == 0);
                chk({tag, "_lpf"}, lpf, e_fault && t_type == 1);
                chk({tag, "_spf"}, spf, e_fault && t_type == 2);
                chk({tag, "_nacc"}, step, e_nacc);
                if (e_fault) chk({tag, "_fva"}, fault_vaddr, t_vaddr);
                if (e_fill) begin
                    lf = t_pte[e_nacc-1];
                    o_ptag = fill_ptag; o_giga = giga;
                    o_mega = mega; o_itlb = fill_itlb;
                    chk({tag, "_ptag"}, fill_ptag, e_ptag);
                    chk({tag, "_giga"}, giga, e_lvl == 2);
                    chk({tag, "_mega"}, mega, e_lvl == 1);
                    chk({tag, "_itlb"}, fill_itlb, t_type == 0);
                    chk({tag, "_va"}, fill_vaddr, t_vaddr);
                    chk({tag, "_uxwr"}, {fu, fx, fw, fr},
                        {lf[4], lf[3], lf[2], lf[1]});
                end
                if (t_zw) chk({tag, "_lat"}, c, 2 * e_nacc + 1);
            end
        end
        if (!done) begin
            n_vec++; n_err++;
            $error("FAIL %s_timeout: observed no result expected one", tag);
        end
        @(negedge clk);
        idle_in();
        #1;
        chk_quiet({tag, "_pulse1"});
        chk({tag, "_idle"}, busy, 0);
    endtask

    function automatic logic [63:0] nl(input logic [43:0] p);
        return {10'h0, p, 10'h001};
    endfunction

    function automatic logic [63:0] lfp(input logic [43:0] p,
                                         input logic [7:0] f);
        return {10'h0, p, 2'b00, f};
    endfunction

    task automatic gen_random();
        logic [63:0] r;
        int L, lvl, k;
        logic [43:0] ppn;
        logic [63:0] p;
        logic rb, xb, wb, ub, ab, db;
        r = {$urandom, $urandom}; t_vaddr = r[38:0];
        r = {$urandom, $urandom}; t_base = r[43:0];
        t_type = $urandom_range(0, 2);
        t_priv = 2'($urandom_range(0, 1));
        t_sum = 1'($urandom_range(0, 1));
        t_mxr = 1'($urandom_range(0, 1));
        t_zw = 1'($urandom_range(0, 1));
        L = $urandom_range(0, 2);
        for (int s = 0; s < 3; s++) begin
            lvl = 2 - s;
            r = {$urandom, $urandom}; ppn = r[43:0];
            if (lvl > L) begin
                p = nl(ppn);
                k = $urandom_range(0, 15);
                if (k == 0) p[0] = 0;
                if (k == 1) p[2] = 1;
            end else if (lvl == L) begin
                rb = 1'($urandom_range(0, 1));
                xb = 1'($urandom_range(0, 1));
                if (!rb && !xb) xb = 1;
                wb = 1'($urandom_range(0, 1));
                ab = ($urandom_range(0, 7) != 0);
                db = ($urandom_range(0, 7) != 0);
                ub = (t_priv == 0) ? ($urandom_range(0, 7) != 0)
                                   : ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0)
                    ppn = (ppn >> (9 * lvl)) << (9 * lvl);
                p = lfp(ppn, {db, ab, 1'b0, ub, xb, wb, rb, 1'b1});
                if (lvl == 0 && $urandom_range(0, 9) == 0) p[3:1] = 3'b000;
            end else begin
                p = {$urandom, $urandom};
            end
            t_pte[s] = p;
        end
    endtask

    task automatic start_walk();
        @(negedge clk); idle_in(); set_miss(); miss_v = 1; #1;
        @(negedge clk); idle_in(); #1;
        chk("ms_send", mem_v, 1);
        mem_ready = 1;
    endtask

    initial begin
        reset_n = 0;
        base_ppn = 0; priv = 0; sum = 0; mxr = 0;
        miss_instr = 0; miss_load = 0; miss_store = 0; miss_vaddr = 0;
        idle_in();
        t_pte[0] = 0; t_pte[1] = 0; t_pte[2] = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_outs", |{mem_v, mem_paddr, fill_v, fill_itlb, fill_vaddr,
                          fill_ptag, giga, mega, fu, fx, fw, fr,
                          ipf, lpf, spf, fault_vaddr}, 0);
        reset_n = 1;

        t_base = 44'h80000; t_vaddr = 39'h0_4020_3000;
        t_type = 1; t_priv = 1; t_sum = 0; t_mxr = 0; t_zw = 1;
        t_pte[0] = nl(44'h80001);
        t_pte[1] = nl(44'h80002);
        t_pte[2] = lfp(44'h90000, 8'hCF);
        run_walk("r030");
        chk("r030_addr0", o_addr0, 56'h80000008);
        chk("r030_ptag_c", o_ptag, 44'h90000);
        chk("r030_mega_c", {o_fill, o_mega}, 2'b10);

        t_vaddr = 39'h12_3456_7000; t_type = 2;
        t_pte[0] = lfp(44'h40000, 8'hCF);
        run_walk("r031");
        chk("r031_giga_c", o_giga, 1);
        chk("r031_ptag_c", o_ptag, {26'h1, t_vaddr[29:12]});

        t_vaddr = 39'h01_2345_6000; t_type = 2; t_zw = 0;
        t_pte[0] = nl(44'h80010);
        t_pte[1] = nl(44'h80020);
        t_pte[2] = lfp(44'h12345, 8'h47);
        run_walk("r032");
        chk("r032_spf_c", {o_spf, o_fill}, 2'b10);

        t_type = 0; t_priv = 1; t_zw = 1;
        t_pte[2] = lfp(44'h12345, 8'hDB);
        run_walk("r033s");
        chk("r033s_ipf_c", {o_ipf, o_fill}, 2'b10);
        t_priv = 0;
        run_walk("r033u");
        chk("r033u_fill_c", {o_fill, o_itlb}, 2'b11);

        t_base = 44'h80000; t_vaddr = 39'h0_4020_3000;
        t_type = 1; t_priv = 1;
        t_pte[0] = nl(44'h80001);
        t_pte[1] = nl(44'h80002);
        t_pte[2] = lfp(44'h90000, 8'hCF);
        start_walk();
        @(negedge clk); idle_in(); flush = 1; #1;
        chk("fw_wait", {mem_v, busy}, 2'b01);
        chk_quiet("fw_q0");
        repeat (2) begin
            @(negedge clk); idle_in(); #1;
            chk("fw_drain", {mem_v, busy}, 2'b01);
            chk_quiet("fw_q1");
        end
        @(negedge clk); idle_in(); mem_data_v = 1;
        mem_data = lfp(44'h90000, 8'hCF); #1;
        chk("fw_drain_rsp", busy, 1);
        @(negedge clk); idle_in(); #1;
        chk("fw_idle", busy, 0);
        chk_quiet("fw_q2");
        run_walk("r034");

        start_walk();
        @(negedge clk); idle_in(); flush = 1; mem_data_v = 1;
        mem_data = nl(44'h80001); #1;
        @(negedge clk); idle_in(); #1;
        chk("fwd_idle", busy, 0);
        chk_quiet("fwd_q");

        @(negedge clk); idle_in(); set_miss(); miss_v = 1; #1;
        @(negedge clk); idle_in(); flush = 1; #1;
        chk("fs_send", mem_v, 1);
        @(negedge clk); idle_in(); #1;
        chk("fs_idle", {busy, mem_v}, 2'b00);

        @(negedge clk); idle_in(); set_miss(); miss_v = 1; flush = 1; #1;
        @(negedge clk); idle_in(); #1;
        chk("fi_drop", {busy, mem_v}, 2'b00);

        start_walk();
        @(negedge clk); idle_in(); mem_data_v = 1;
        mem_data = lfp(44'h40000, 8'hCF); #1;
        @(negedge clk); idle_in(); flush = 1; #1;
        chk("fd_done", {busy, fill_v}, 2'b10);
        chk_quiet("fd_q");
        @(negedge clk); idle_in(); #1;
        chk("fd_idle", busy, 0);
        chk_quiet("fd_q2");

        start_walk();
        @(negedge clk); idle_in(); flush = 1; #1;
        @(negedge clk); idle_in(); flush = 1; mem_data_v = 1; #1;
        chk("dk_drain", busy, 1);
        @(negedge clk); idle_in(); #1;
        chk("dk_hold", busy, 1);
        mem_data_v = 1;
        @(negedge clk); idle_in(); #1;
        chk("dk_idle", busy, 0);
        chk_quiet("dk_q");

        start_walk();
        @(negedge clk); idle_in(); #1;
        chk("rw_wait", busy, 1);
        reset_n = 0; #1;
        chk("rw_busy", busy, 0);
        chk("rw_outs", |{mem_v, mem_paddr, fill_v, fill_itlb, fill_vaddr,
                         fill_ptag, giga, mega, fu, fx, fw, fr,
                         ipf, lpf, spf, fault_vaddr}, 0);
        @(negedge clk); idle_in(); reset_n = 1; #1;
        @(negedge clk); idle_in(); mem_data_v = 1;
        mem_data = lfp(44'h90000, 8'hCF); #1;
        chk("rw_stale", busy, 0);
        @(negedge clk); idle_in(); #1;
        chk("rw_idle", busy, 0);
        chk_quiet("rw_q");
        run_walk("rw_next");

        for (int i = 0; i < 40; i++) begin
            gen_random();
            run_walk($sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
